// File: rtl/serial_addsub.sv
`default_nettype none
// ----------------------------------------------------------------------------
// serial_addsub : digit-serial add/subtract, DIGIT bits per clock, LSB first
// Revision      : 1.0
// ----------------------------------------------------------------------------
module serial_addsub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cbin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cbout,
  output logic             ovf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int SW   = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc;
  logic             mode_q;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [SW-1:0]    shamt;
  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic [DIGIT:0]   ext;
  logic             carry_nxt;
  logic [WIDTH-1:0] acc_nxt;
  logic             last;
  logic             ovf_nxt;

  // The top bit of the (DIGIT+1)-bit digit result is the carry for add and,
  // being the sign of a-b-c, the borrow for subtract.
  always_comb begin
    shamt     = SW'(cnt) * SW'(DIGIT);
    a_dig     = DIGIT'(a_q >> shamt);
    b_dig     = DIGIT'(b_q >> shamt);
    if (mode_q)
      ext = {1'b0, a_dig} - {1'b0, b_dig} - (DIGIT+1)'(carry);
    else
      ext = {1'b0, a_dig} + {1'b0, b_dig} + (DIGIT+1)'(carry);
    carry_nxt = ext[DIGIT];
    acc_nxt   = (acc >> DIGIT) | (WIDTH'(ext[DIGIT-1:0]) << (WIDTH - DIGIT));
    last      = (cnt == CW'(NDIG - 1));
    if (mode_q)
      ovf_nxt = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (acc_nxt[WIDTH-1] != a_q[WIDTH-1]);
    else
      ovf_nxt = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (acc_nxt[WIDTH-1] != a_q[WIDTH-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      acc    <= '0;
      mode_q <= 1'b0;
      carry  <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cbout  <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_q    <= A;
            b_q    <= B;
            mode_q <= mode;
            carry  <= cbin;
            cnt    <= '0;
            acc    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end else begin
            state  <= IDLE;
          end
        end
        RUN: begin
          carry <= carry_nxt;
          acc   <= acc_nxt;
          if (last) begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= acc_nxt;
            cbout  <= carry_nxt;
            ovf    <= ovf_nxt;
            cnt    <= '0;
          end else begin
            cnt    <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_addsub.sv
`default_nettype none
// Bench for serial_addsub: directed cases on DIGIT=4 plus a random sweep over
// DIGIT in {1,2,4,16}, all scored against a plain-arithmetic reference.
module tb_serial_addsub;

  localparam int W    = 16;
  localparam int NI   = 4;
  localparam int NOPS = 1000;

  typedef struct {
    logic [W-1:0] res;
    logic         cb;
    logic         ov;
    int           issue;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;
  bit dir_done = 1'b0;
  bit sweep_done [NI];

  function automatic exp_t model(logic m, logic [W-1:0] a, logic [W-1:0] b, logic c);
    exp_t   e;
    longint ua, ub, uc, r, sa, sb, sr;
    ua = longint'(a);
    ub = longint'(b);
    uc = longint'(c);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!m) begin
      r    = ua + ub + uc;
      sr   = sa + sb + uc;
      e.cb = (r >= 65536);
    end else begin
      r    = ua - ub - uc;
      sr   = sa - sb - uc;
      e.cb = (ua < ub + uc);
    end
    e.res   = r[W-1:0];
    e.ov    = (sr > 32767) || (sr < -32768);
    e.issue = 0;
    return e;
  endfunction

  task automatic check(string name, int d, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s (DIGIT=%0d): got %0h expected %0h", name, d, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(7))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      default: return W'($urandom);
    endcase
  endfunction

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int DIG  = (gi == 0) ? 1 : (gi == 1) ? 2 : (gi == 2) ? 4 : 16;
    localparam int NDIG = W / DIG;

    logic         start, mode, cbin, busy, done, cbout, ovf;
    logic [W-1:0] a, b, result;
    exp_t         expq[$];
    exp_t         mon_e;
    logic [W-1:0] last_res = '0;
    logic         last_cb  = 1'b0;
    logic         last_ov  = 1'b0;

    serial_addsub #(.WIDTH(W), .DIGIT(DIG)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .A(a), .B(b),
      .cbin(cbin), .busy(busy), .done(done), .result(result), .cbout(cbout), .ovf(ovf)
    );

    // Monitor: scores every done pulse and checks outputs hold during RUN.
    always @(negedge clk) begin
      if (rst_n) begin
        if (done) begin
          if (expq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL done_unexpected (DIGIT=%0d): got done=1 expected no pending op", DIG);
          end else begin
            mon_e = expq.pop_front();
            check("result",  DIG, 64'(result), 64'(mon_e.res));
            check("cbout",   DIG, 64'(cbout),  64'(mon_e.cb));
            check("ovf",     DIG, 64'(ovf),    64'(mon_e.ov));
            check("latency", DIG, 64'(cyc - mon_e.issue), 64'(NDIG));
            last_res = mon_e.res;
            last_cb  = mon_e.cb;
            last_ov  = mon_e.ov;
          end
        end else if (busy) begin
          check("hold_in_run", DIG, 64'({result, cbout, ovf}), 64'({last_res, last_cb, last_ov}));
        end
      end
    end

    task automatic issue(logic m, logic [W-1:0] av, logic [W-1:0] bv, logic c);
      exp_t e;
      e       = model(m, av, bv, c);
      e.issue = cyc + 1;
      expq.push_back(e);
      mode  = m;
      a     = av;
      b     = bv;
      cbin  = c;
      start = 1'b1;
    endtask

    task automatic wait_done();
      int g;
      g = 0;
      while (!done && g < 100) begin
        @(negedge clk);
        g++;
      end
      check("done_timeout", DIG, 64'(done), 64'(1));
    endtask

    task automatic rand_run();
      for (int n = 0; n < NOPS; n++) begin
        issue(1'($urandom_range(1)), rnd_operand(), rnd_operand(), 1'($urandom_range(1)));
        @(negedge clk);
        start = 1'b0;
        for (int g = 0; g < 100 && !done; g++) begin
          if (busy && $urandom_range(3) == 0) begin
            start = 1'b1;
            a     = W'($urandom);
            b     = W'($urandom);
            mode  = 1'($urandom_range(1));
            cbin  = 1'($urandom_range(1));
          end else begin
            start = 1'b0;
          end
          @(negedge clk);
        end
        check("rand_done_seen", DIG, 64'(done), 64'(1));
        if (n == NOPS - 1 || $urandom_range(1) == 1) begin
          start = 1'b0;
          repeat ($urandom_range(1, 3)) @(negedge clk);
        end
      end
      start = 1'b0;
    endtask

    if (gi == 2) begin : g_directed
      task automatic run_spec(logic m, logic [W-1:0] av, logic [W-1:0] bv, logic c,
                              logic [W-1:0] er, logic ec, logic eo, string name);
        issue(m, av, bv, c);
        @(negedge clk);
        start = 1'b0;
        wait_done();
        check({name, "_result"}, DIG, 64'(result), 64'(er));
        check({name, "_cbout"},  DIG, 64'(cbout),  64'(ec));
        check({name, "_ovf"},    DIG, 64'(ovf),    64'(eo));
        @(negedge clk);
      endtask

      initial begin
        int nb, g;
        rst_n = 1'b0;
        start = 1'b0; mode = 1'b0; a = '0; b = '0; cbin = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", DIG, 64'({busy, done, result, cbout, ovf}), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        issue(1'b0, 16'h1234, 16'h4321, 1'b0);
        @(negedge clk);
        start = 1'b0;
        nb = 0;
        g  = 0;
        while (!done && g < 20) begin
          nb += int'(busy);
          @(negedge clk);
          g++;
        end
        check("busy_cycles",  DIG, 64'(nb), 64'(4));
        check("busy_at_done", DIG, 64'(busy), 64'(0));
        check("add_5555",     DIG, 64'({result, cbout, ovf}), 64'({16'h5555, 1'b0, 1'b0}));
        @(negedge clk);

        run_spec(1'b1, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, "sub_wrap");
        run_spec(1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, "sub_ovf");
        run_spec(1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "add_ovf");
        run_spec(1'b0, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, "add_carry");

        // Start and operand changes during RUN are ignored; then back-to-back.
        issue(1'b0, 16'h1111, 16'h2222, 1'b1);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; mode = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        check("ignore_start", DIG, 64'(result), 64'(16'h3334));
        issue(1'b1, 16'h5000, 16'h1234, 1'b0);
        @(negedge clk);
        start = 1'b0;
        check("done_gap", DIG, 64'({done, busy}), 64'({1'b0, 1'b1}));
        wait_done();
        check("b2b_result", DIG, 64'(result), 64'(16'h3DCC));
        @(negedge clk);

        // Asynchronous reset in the middle of RUN.
        issue(1'b0, 16'hAAAA, 16'h5555, 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("reset_async", DIG, 64'({busy, done, result, cbout, ovf}), 64'(0));
        expq.delete();
        last_res = '0;
        last_cb  = 1'b0;
        last_ov  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
          @(negedge clk);
          check("no_done_after_reset", DIG, 64'(done), 64'(0));
        end
        run_spec(1'b0, 16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b0, "post_reset");

        dir_done = 1'b1;
        rand_run();
        sweep_done[gi] = 1'b1;
      end
    end else begin : g_sweep_only
      initial begin
        start = 1'b0; mode = 1'b0; a = '0; b = '0; cbin = 1'b0;
        wait (dir_done);
        @(negedge clk);
        rand_run();
        sweep_done[gi] = 1'b1;
      end
    end
  end

  initial begin
    bit all_done;
    all_done = 1'b0;
    for (int g = 0; g < 90000 && !all_done; g++) begin
      @(negedge clk);
      all_done = sweep_done[0] && sweep_done[1] && sweep_done[2] && sweep_done[3];
    end
    repeat (2) @(negedge clk);
    check("sweep_complete", 0, 64'(all_done), 64'(1));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
